// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver.
// Holds the receiver state encoding, the default frame constants shared with
// the transmitter and baud generator, and a parity helper.
package uart_rx_pkg;

  localparam int unsigned DefDataBits   = 8;
  localparam int unsigned DefOversample = 16;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4,
    StBreak  = 3'd5
  } rx_state_e;

  // Expected parity bit for up to 9 data bits; unused upper bits must be zero.
  function automatic logic parity_bit(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset; both flops load ResetVal
//   d_i    - asynchronous input
//   q_o    - synchronised output
module uart_rx_sync_2ff #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x (configurable) oversampling and mid-bit sampling.
// Recovers start / DATA_BITS data (LSB first) / optional parity / stop frames.
// Ports:
//   clk_i          - system clock
//   rst_i          - asynchronous active-high reset
//   rx_tick_i      - one-cycle enable at OVERSAMPLE x baud
//   rx_serial_i    - asynchronous serial line, idle high
//   rx_data_o      - last correctly framed byte, held until the next one
//   rx_valid_o     - one-cycle pulse when rx_data_o updates
//   parity_error_o - one-cycle pulse with rx_valid_o when parity is wrong
//   frame_error_o  - one-cycle pulse when the stop bit is sampled low
//   rx_busy_o      - high whenever the receiver is not idle
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned OVERSAMPLE = DefOversample,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_tick_i,
  input  logic                 rx_serial_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 parity_error_o,
  output logic                 frame_error_o,
  output logic                 rx_busy_o
);

  localparam int unsigned CntW  = $clog2(OVERSAMPLE);
  localparam int unsigned BitnW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0]  CntHalf  = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0]  CntLast  = CntW'(OVERSAMPLE - 1);
  localparam logic [BitnW-1:0] BitnLast = BitnW'(DATA_BITS - 1);
  localparam logic             ParOdd   = (PARITY_ODD != 0);
  localparam logic             ParEn    = (PARITY_EN != 0);

  logic rxs;

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BitnW-1:0]     bitn_q, bitn_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  uart_rx_sync_2ff #(
    .ResetVal (1'b1)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_serial_i),
    .q_o   (rxs)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bitn_d  = bitn_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    // Output strobes clear every cycle, independent of the tick.
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (rx_tick_i) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d = StStart;
            cnt_d   = '0;
          end
        end

        StStart: begin
          if (cnt_q == CntHalf) begin
            cnt_d  = '0;
            bitn_d = '0;
            // A start bit that is gone by mid-bit is treated as a glitch.
            state_d = rxs ? StIdle : StData;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StData: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bitn_q == BitnLast) begin
              bitn_d  = '0;
              state_d = ParEn ? StParity : StStop;
            end else begin
              bitn_d = bitn_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            par_d   = rxs;
            state_d = StStop;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_d = '0;
            if (rxs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              perr_d  = ParEn && (par_q != parity_bit(9'(shift_q), ParOdd));
              // Returning at mid-stop lets a following start edge be caught.
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        StBreak: begin
          if (rxs) begin
            state_d = StIdle;
          end
        end

        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          bitn_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bitn_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bitn_q  <= bitn_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data_o      = data_q;
  assign rx_valid_o     = valid_q;
  assign parity_error_o = perr_q;
  assign frame_error_o  = ferr_q;
  assign rx_busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one instance without parity, one with even parity.
// Ticks every 4 clocks, 16x oversampling, so one bit period is 64 clocks.
module tb_uart_rx;

  localparam int BitClks = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] data0, data1;
  logic       valid0, valid1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .PARITY_EN  (0),
    .PARITY_ODD (0)
  ) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_tick_i      (tick),
    .rx_serial_i    (rx0),
    .rx_data_o      (data0),
    .rx_valid_o     (valid0),
    .parity_error_o (perr0),
    .frame_error_o  (ferr0),
    .rx_busy_o      (busy0)
  );

  uart_rx #(
    .DATA_BITS  (8),
    .OVERSAMPLE (16),
    .PARITY_EN  (1),
    .PARITY_ODD (0)
  ) u_dut_par (
    .clk_i          (clk),
    .rst_i          (rst),
    .rx_tick_i      (tick),
    .rx_serial_i    (rx1),
    .rx_data_o      (data1),
    .rx_valid_o     (valid1),
    .parity_error_o (perr1),
    .frame_error_o  (ferr1),
    .rx_busy_o      (busy1)
  );

  always #5 clk = ~clk;

  int tdiv = 0;
  always @(negedge clk) begin
    tdiv = (tdiv + 1) % 4;
    tick = (tdiv == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         v_cnt[2];
  int         p_cnt[2];
  int         f_cnt[2];
  int         v_time[$];
  logic [7:0] v_dq[$];
  always @(negedge clk) begin
    if (valid0) begin
      v_cnt[0]++;
      v_time.push_back(cyc);
      v_dq.push_back(data0);
    end
    if (perr0) p_cnt[0]++;
    if (ferr0) f_cnt[0]++;
    if (valid1) v_cnt[1]++;
    if (perr1) p_cnt[1]++;
    if (ferr1) f_cnt[1]++;
  end

  int         cmp_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] hold[2];

  task automatic chk(input string nm, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_line(input int w, input logic v);
    if (w == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic hold_bits(input int w, input logic v, input int nbits);
    set_line(w, v);
    repeat (nbits * BitClks) @(negedge clk);
  endtask

  task automatic send_frame(input int w, input logic [7:0] d, input logic pb,
                            input logic sb);
    hold_bits(w, 1'b0, 1);
    for (int i = 0; i < 8; i++) hold_bits(w, d[i], 1);
    if (w == 1) hold_bits(w, pb, 1);
    hold_bits(w, sb, 1);
  endtask

  function automatic int cur_data(input int w);
    return (w == 0) ? int'(data0) : int'(data1);
  endfunction

  function automatic int cur_busy(input int w);
    return (w == 0) ? int'(busy0) : int'(busy1);
  endfunction

  // Send one frame followed by idle, then compare pulse counts and held data.
  task automatic frame_and_check(input string nm, input int w, input logic [7:0] d,
                                 input logic pb, input logic sb, input int gap,
                                 input int ev, input int ed, input int ep, input int ef);
    int vs, ps, fs;
    vs = v_cnt[w];
    ps = p_cnt[w];
    fs = f_cnt[w];
    send_frame(w, d, pb, sb);
    set_line(w, 1'b1);
    repeat (gap) @(negedge clk);
    chk({nm, ".valid"}, v_cnt[w] - vs, ev);
    chk({nm, ".data"}, cur_data(w), ed);
    chk({nm, ".perr"}, p_cnt[w] - ps, ep);
    chk({nm, ".ferr"}, f_cnt[w] - fs, ef);
    chk({nm, ".busy"}, cur_busy(w), 0);
  endtask

  typedef struct {
    int         w;
    logic [7:0] d;
    logic       pb;
    logic       sb;
    int         ev;
    int         ed;
    int         ep;
    int         ef;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int vs, fs, n;

    vecs[0] = '{w: 0, d: 8'hA5, pb: 1'b0, sb: 1'b1, ev: 1, ed: 'hA5, ep: 0, ef: 0};
    vecs[1] = '{w: 1, d: 8'h07, pb: 1'b1, sb: 1'b1, ev: 1, ed: 'h07, ep: 0, ef: 0};
    vecs[2] = '{w: 1, d: 8'h07, pb: 1'b0, sb: 1'b1, ev: 1, ed: 'h07, ep: 1, ef: 0};
    vecs[3] = '{w: 0, d: 8'h3C, pb: 1'b0, sb: 1'b0, ev: 0, ed: 'hA5, ep: 0, ef: 1};
    vecs[4] = '{w: 1, d: 8'hC3, pb: 1'b1, sb: 1'b0, ev: 0, ed: 'h07, ep: 0, ef: 1};
    vecs[5] = '{w: 1, d: 8'h80, pb: 1'b1, sb: 1'b1, ev: 1, ed: 'h80, ep: 0, ef: 0};
    vecs[6] = '{w: 0, d: 8'h01, pb: 1'b0, sb: 1'b1, ev: 1, ed: 'h01, ep: 0, ef: 0};
    vecs[7] = '{w: 1, d: 8'hFF, pb: 1'b1, sb: 1'b1, ev: 1, ed: 'hFF, ep: 1, ef: 0};

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst.data0", int'(data0), 0);
    chk("rst.valid0", int'(valid0), 0);
    chk("rst.busy0", int'(busy0), 0);
    chk("rst.ferr0", int'(ferr0), 0);
    chk("rst.perr0", int'(perr0), 0);
    chk("rst.data1", int'(data1), 0);
    chk("rst.busy1", int'(busy1), 0);
    rst = 1'b0;
    repeat (BitClks) @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      frame_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].d, vecs[i].pb, vecs[i].sb,
                      BitClks, vecs[i].ev, vecs[i].ed, vecs[i].ep, vecs[i].ef);
    end
    hold[0] = 8'h01;
    hold[1] = 8'hFF;

    // Start glitch: 3 ticks low, then high
    vs = v_cnt[0];
    fs = f_cnt[0];
    set_line(0, 1'b0);
    repeat (12) @(negedge clk);
    set_line(0, 1'b1);
    chk("glitch.busy_mid", int'(busy0), 1);
    repeat (2 * BitClks) @(negedge clk);
    chk("glitch.valid", v_cnt[0] - vs, 0);
    chk("glitch.ferr", f_cnt[0] - fs, 0);
    chk("glitch.busy", int'(busy0), 0);
    chk("glitch.data", int'(data0), int'(hold[0]));

    // Back-to-back 0x00, 0xFF with no idle gap
    n = v_time.size();
    send_frame(0, 8'h00, 1'b0, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1);
    hold_bits(0, 1'b1, 1);
    chk("b2b.count", v_time.size() - n, 2);
    if (v_time.size() - n == 2) begin
      chk("b2b.first", int'(v_dq[n]), 'h00);
      chk("b2b.second", int'(v_dq[n+1]), 'hFF);
      chk("b2b.spacing", v_time[n+1] - v_time[n], 10 * BitClks);
    end
    hold[0] = 8'hFF;

    // Stop bit low followed by a long break
    vs = v_cnt[0];
    fs = f_cnt[0];
    hold_bits(0, 1'b0, 1);
    for (int i = 0; i < 8; i++) hold_bits(0, (8'h3C >> i) & 8'h01, 1);
    hold_bits(0, 1'b0, 21);
    chk("brk.busy_low", int'(busy0), 1);
    chk("brk.ferr", f_cnt[0] - fs, 1);
    chk("brk.valid", v_cnt[0] - vs, 0);
    chk("brk.data", int'(data0), int'(hold[0]));
    hold_bits(0, 1'b1, 2);
    chk("brk.busy_after", int'(busy0), 0);
    chk("brk.ferr_after", f_cnt[0] - fs, 1);
    chk("brk.valid_after", v_cnt[0] - vs, 0);

    // Reset during data bit 4 of 0x55, then 0x81
    vs = v_cnt[0];
    hold_bits(0, 1'b0, 1);
    for (int i = 0; i < 4; i++) hold_bits(0, (8'h55 >> i) & 8'h01, 1);
    set_line(0, 1'b1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst.busy", int'(busy0), 0);
    chk("mrst.data", int'(data0), 0);
    rst = 1'b0;
    hold_bits(0, 1'b1, 2);
    chk("mrst.nopulse", v_cnt[0] - vs, 0);
    hold[0] = 8'h00;
    hold[1] = 8'h00;
    frame_and_check("mrst.next", 0, 8'h81, 1'b0, 1'b1, BitClks, 1, 'h81, 0, 0);
    hold[0] = 8'h81;

    // Randomised frames against the frame-level model
    for (int k = 0; k < 24; k++) begin
      int         w, ev, ed, ep, ef;
      logic [7:0] d;
      logic       pb, sb;
      w  = k % 2;
      d  = 8'($urandom);
      pb = 1'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      ev = sb ? 1 : 0;
      ef = sb ? 0 : 1;
      ed = sb ? int'(d) : int'(hold[w]);
      ep = (sb && w == 1 && (pb != (^d))) ? 1 : 0;
      frame_and_check($sformatf("rnd%0d", k), w, d, pb, sb,
                      BitClks + int'($urandom_range(0, 40)), ev, ed, ep, ef);
      if (sb) hold[w] = d;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side consumer of the baud generator's oversampled receive tick.
- Recovers 8N1 frames (optional parity) from an asynchronous serial line using 16x oversampling and a mid-bit sample.
- Delivers each byte with a one-cycle valid strobe, plus framing and parity error flags.
- Sits between the board RX pin and the UART host-side logic.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..9), LSB first.
- OVERSAMPLE, 16, RX_Tick pulses per bit period; even, minimum 8.
- PARITY_EN, 0, 1 = a parity bit follows the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).

Ports:
- Clock  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  asynchronous, active-high reset.
- RX_Tick  in  1  one-Clock-wide enable at OVERSAMPLE x baud, from the baud generator.
- RX_Serial  in  1  asynchronous serial line; idle level is 1.
- RX_Data  out  DATA_BITS  last correctly framed byte; holds its value until the next good frame.
- RX_Valid  out  1  one-cycle pulse when RX_Data is updated.
- Parity_Error  out  1  one-cycle pulse coincident with RX_Valid when the parity check fails.
- Frame_Error  out  1  one-cycle pulse when the stop bit is sampled as 0.
- RX_Busy  out  1  high in every state except IDLE.

Behaviour:
- Input synchroniser: RX_Serial passes through 2 flops before use; both flops reset to 1. All decisions use the synchronised value `rxs`.
- Reset: state=IDLE, tick counter=0, bit counter=0, shift register=0, RX_Data=0, RX_Valid=0, Parity_Error=0, Frame_Error=0, RX_Busy=0.
- All state and counter updates occur only on cycles where RX_Tick=1, except the output-pulse clears, which occur every cycle.
- States and transitions:
  - IDLE: on tick with rxs=0 -> START, cnt=0.
  - START: cnt increments each tick. At cnt==OVERSAMPLE/2-1, sample rxs:
    - rxs=0 -> DATA, cnt=0, bitn=0.
    - rxs=1 -> IDLE (glitch reject; no flags raised).
  - DATA: at cnt==OVERSAMPLE-1, sample rxs into the MSB of the shift register, shifting right (LSB-first reconstruction). Then cnt=0 and bitn++. After DATA_BITS samples:
    - -> PARITY if PARITY_EN=1,
    - else -> STOP.
  - PARITY: at cnt==OVERSAMPLE-1, latch the parity bit, then -> STOP. Expected parity bit = XOR(data) ^ PARITY_ODD.
  - STOP: at cnt==OVERSAMPLE-1, sample rxs:
    - rxs=1 -> load RX_Data from the shift register, pulse RX_Valid (and Parity_Error if the check failed), -> IDLE.
    - rxs=0 -> pulse Frame_Error; RX_Data is unchanged and RX_Valid is not asserted; -> BREAK.
  - BREAK: wait for a tick with rxs=1, then -> IDLE. A line held low never retriggers a frame.
- Latency: RX_Valid and the error flags are registered. They assert in the Clock cycle immediately after the tick that samples the stop bit, and are high for exactly one Clock cycle.
- Back-to-back frames: IDLE is entered at mid-stop-bit, so a start edge arriving half a bit later is accepted. There are no dead cycles beyond the sampling point.
- Counter widths: cnt is clog2(OVERSAMPLE) bits; bitn is clog2(DATA_BITS+1) bits. Neither counter wraps in normal operation, because both are cleared at each terminal count.
- RX_Tick held constantly high is legal: the block then oversamples at Clock rate.
- Reset asserted mid-frame: everything returns immediately to reset values; any partial byte is discarded and no pulse is emitted.
- Reset deasserted while the line is low: the receiver starts from IDLE and treats the low level as a start bit. This is accepted behaviour.

Decomposition:
- Shared include `uart_defs.vh`, containing:
  - state encodings (IDLE, START, DATA, PARITY, STOP, BREAK as 3-bit localparams),
  - default DATA_BITS and OVERSAMPLE constants, shared with the transmitter and the baud generator.
- One sub-module: `sync_2ff` (parameterised reset value, here 1), reused for any asynchronous input.

Test Plan:
- Setup for all scenarios: RX_Tick every 4 Clocks, OVERSAMPLE=16, PARITY_EN=0.
- Send 0xA5 (8N1) -> exactly one RX_Valid pulse with RX_Data=0xA5, no error flags, RX_Busy low after the stop sample.
- Back-to-back frames 0x00 then 0xFF with no idle gap -> two RX_Valid pulses, RX_Data 0x00 then 0xFF, spaced 10 bit periods (640 Clocks).
- Pull RX_Serial low for 3 ticks, then high -> returns to IDLE, no RX_Valid, no Frame_Error, RX_Data unchanged.
- Send 0x3C with stop bit 0, then hold the line low for 20 bit periods -> one Frame_Error pulse, no RX_Valid, RX_Data unchanged, no further frames until the line returns high.
- PARITY_EN=1, PARITY_ODD=0:
  - 0x07 with parity bit 1 -> RX_Valid, RX_Data=0x07, Parity_Error=0.
  - 0x07 with parity bit 0 -> RX_Valid with Parity_Error=1.
- Assert Reset during data bit 4 of 0x55, release, then send 0x81 -> no pulse for the aborted frame; a single RX_Valid with RX_Data=0x81.
